// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and flag bit indices shared by the ALU sequencer
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MPY = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam int F_ZF = 4;
  localparam int F_CF = 3;
  localparam int F_OF = 2;
  localparam int F_NF = 1;
  localparam int F_MF = 0;
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: iterative sign-magnitude multiplier (and divider when ALU_SEQ_DIV_EN is defined)
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [4:0]       flags
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  logic [WIDTH:0] hi, hi_c, hi_n, sum;
  logic [WIDTH-1:0] lo, lo_c, lo_n, m, m_c, m_ld, lo_ld, p_abs, q_abs;
  logic [2*WIDTH-1:0] mag, prod;
  logic neg, neg_c, busy;
  assign p_abs = p[WIDTH-1] ? -p : p;
  assign q_abs = q[WIDTH-1] ? -q : q;
  assign busy = cnt != '0;
  assign done = busy && cnt == CW'(WIDTH - 1);
`ifdef ALU_SEQ_DIV_EN
  logic dv, dv_c, rneg, rneg_c;
  logic [WIDTH:0] shl, trial;
  assign dv_c = start ? div : dv;
  assign rneg_c = start ? p[WIDTH-1] : rneg;
  assign m_ld = div ? q_abs : p_abs;
  assign lo_ld = div ? p_abs : q_abs;
  // divider-only context: operation kind and remainder sign
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      dv <= 1'b0;
      rneg <= 1'b0;
    end else if (start || busy) begin
      dv <= dv_c;
      rneg <= rneg_c;
    end
`else
  assign m_ld = p_abs;
  assign lo_ld = q_abs;
`endif
  // one iteration step; the accepting edge already performs the first step on fresh operands
  always_comb begin
    hi_c = start ? '0 : hi;
    lo_c = start ? lo_ld : lo;
    m_c = start ? m_ld : m;
    neg_c = start ? p[WIDTH-1] ^ q[WIDTH-1] : neg;
    sum = hi_c + {1'b0, lo_c[0] ? m_c : '0};
    hi_n = {1'b0, sum[WIDTH:1]};
    lo_n = {sum[0], lo_c[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    shl = {hi_c[WIDTH-1:0], lo_c[WIDTH-1]};
    trial = shl - {1'b0, m_c};
    if (dv_c) begin
      hi_n = trial[WIDTH] ? shl : trial;
      lo_n = {lo_c[WIDTH-2:0], ~trial[WIDTH]};
    end
`endif
  end
  assign mag = {hi_n[WIDTH-1:0], lo_n};
  assign prod = neg_c ? -mag : mag;
  // final signed result and flags, valid while done is high
  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    flags = '0;
    flags[F_ZF] = prod == '0;
    flags[F_OF] = res_hi != {WIDTH{res_lo[WIDTH-1]}};
    flags[F_NF] = res_lo[WIDTH-1];
    flags[F_MF] = 1'b1;
`ifdef ALU_SEQ_DIV_EN
    if (dv_c) begin
      res_lo = neg_c ? -lo_n : lo_n;
      res_hi = rneg_c ? -hi_n[WIDTH-1:0] : hi_n[WIDTH-1:0];
      flags[F_ZF] = res_lo == '0;
      flags[F_OF] = !neg_c && lo_n == {1'b1, {(WIDTH-1){1'b0}}};
      flags[F_NF] = res_lo[WIDTH-1];
    end
`endif
  end
  // iteration state and counter; counter value 0 means idle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      neg <= 1'b0;
    end else if (start || busy) begin
      cnt <= done ? '0 : cnt + 1'b1;
      hi <= hi_n;
      lo <= lo_n;
      m <= m_c;
      neg <= neg_c;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with IDLE/CALC/DONE control; DIV enabled by ALU_SEQ_DIV_EN
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_acc_alu_p,
  input  logic [WIDTH-1:0] i_acc_alu_q,
  input  logic [3:0]       ctrl_alu_op,
  input  logic             i_start,
  input  logic             C9,
  input  logic             C10,
  output logic [WIDTH-1:0] o_br,
  output logic [WIDTH-1:0] o_mr,
  output logic [4:0]       o_flags,
  output logic             o_busy,
  output logic             o_done
);
  state_e state;
  logic [WIDTH-1:0] p, q, br, mr, sc_br, sc_mr, it_hi, it_lo;
  logic [4:0] sc_flags, it_flags;
  logic sc_cf, sc_of, sc_mf, is_iter, it_start, it_done;
  assign p = i_acc_alu_p;
  assign q = i_acc_alu_q;
  assign o_br = C9 ? br : '0;
  assign o_mr = C10 ? mr : '0;
  assign it_start = state == IDLE && i_start && is_iter;
  // single-cycle results and flags; also decides which opcodes go iterative
  always_comb begin
    sc_br = '0;
    sc_mr = '0;
    sc_cf = 1'b0;
    sc_of = 1'b0;
    sc_mf = 1'b0;
    is_iter = 1'b0;
    case (ctrl_alu_op)
      OP_ADD: begin
        sc_br = p + q;
        sc_of = p[WIDTH-1] == q[WIDTH-1] && sc_br[WIDTH-1] != p[WIDTH-1];
      end
      OP_SUB: begin
        sc_br = p - q;
        sc_of = p[WIDTH-1] != q[WIDTH-1] && sc_br[WIDTH-1] != p[WIDTH-1];
      end
      OP_MPY: is_iter = 1'b1;
      OP_AND: sc_br = p & q;
      OP_OR:  sc_br = p | q;
      OP_NOT: sc_br = ~p;
      OP_SHL: begin
        sc_br = {p[WIDTH-2:0], 1'b0};
        sc_cf = p[WIDTH-1];
      end
      OP_SHR: begin
        sc_br = {p[WIDTH-1], p[WIDTH-1:1]};
        sc_cf = p[0];
      end
      OP_XOR: sc_br = p ^ q;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        is_iter = q != '0;
        sc_mr = p;
        sc_of = 1'b1;
        sc_mf = 1'b1;
      end
`endif
      default: ;
    endcase
    sc_flags = '0;
    sc_flags[F_ZF] = sc_br == '0;
    sc_flags[F_CF] = sc_cf;
    sc_flags[F_OF] = sc_of;
    sc_flags[F_NF] = sc_br[WIDTH-1];
    sc_flags[F_MF] = sc_mf;
  end
  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .start   (it_start),
`ifdef ALU_SEQ_DIV_EN
    .div     (ctrl_alu_op == OP_DIV),
`endif
    .p       (p),
    .q       (q),
    .done    (it_done),
    .res_hi  (it_hi),
    .res_lo  (it_lo),
    .flags   (it_flags)
  );
  // control FSM with registered BR/MR/flags, busy and done
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      br <= '0;
      mr <= '0;
      o_flags <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          o_busy <= 1'b1;
          if (is_iter) state <= CALC;
          else begin
            br <= sc_br;
            mr <= sc_mr;
            o_flags <= sc_flags;
            o_done <= 1'b1;
            state <= DONE;
          end
        end
        CALC: if (it_done) begin
          br <= it_lo;
          mr <= it_hi;
          o_flags <= it_flags;
          o_done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          o_busy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized scoreboard bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
  typedef struct {
    logic [15:0] br;
    logic [15:0] mr;
    logic [4:0]  fl;
    int          lat;
    int          acc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, c9 = 1'b1, c10 = 1'b1;
  logic [15:0] p = '0, q = '0;
  logic [3:0] op = '0;
  logic [15:0] o_br, o_mr;
  logic [4:0] o_flags;
  logic o_busy, o_done;
  int cyc = 0, vectors = 0, fails = 0;
  exp_t sbq[$];
  exp_t last;
  alu_seq #(.WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_acc_alu_p(p), .i_acc_alu_q(q),
    .ctrl_alu_op(op), .i_start(start), .C9(c9), .C10(c10),
    .o_br(o_br), .o_mr(o_mr), .o_flags(o_flags), .o_busy(o_busy), .o_done(o_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction
  function automatic exp_t model(input logic [3:0] o, input logic [15:0] pa, input logic [15:0] qa);
    exp_t e;
    longint sp, sq, r;
    logic zf, cf, of, mf;
    sp = longint'($signed(pa));
    sq = longint'($signed(qa));
    r = 0;
    e.br = '0; e.mr = '0; e.lat = 1; e.acc = 0;
    cf = 1'b0; of = 1'b0; mf = 1'b0;
    case (o)
      4'd0: begin r = sp + sq; of = r > 32767 || r < -32768; e.br = r[15:0]; end
      4'd1: begin r = sp - sq; of = r > 32767 || r < -32768; e.br = r[15:0]; end
      4'd2: begin
        r = sp * sq; of = r > 32767 || r < -32768; mf = 1'b1; e.lat = 16;
        e.br = r[15:0]; e.mr = r[31:16];
      end
      4'd3: e.br = pa & qa;
      4'd4: e.br = pa | qa;
      4'd5: e.br = ~pa;
      4'd6: begin r = sp * 2; e.br = r[15:0]; cf = pa[15]; end
      4'd7: begin r = sp >>> 1; e.br = r[15:0]; cf = pa[0]; end
      4'd8: e.br = pa ^ qa;
`ifdef ALU_SEQ_DIV_EN
      4'd9: begin
        mf = 1'b1;
        if (sq == 0) begin e.mr = pa; of = 1'b1; end
        else begin
          r = sp / sq; of = r > 32767; e.br = r[15:0];
          r = sp % sq; e.mr = r[15:0]; e.lat = 16;
        end
      end
`endif
      default: ;
    endcase
    zf = (o == 4'd2) ? ({e.mr, e.br} == 32'd0) : (e.br == 16'd0);
    e.fl = {zf, cf, of, e.br[15], mf};
    return e;
  endfunction
  function automatic logic [15:0] pick();
    case ($urandom_range(0, 6))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction
  // monitor: every o_done pops one expectation from the scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (o_done) begin
      if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("br", {16'd0, o_br}, {16'd0, c9 ? e.br : 16'd0});
        chk("mr", {16'd0, o_mr}, {16'd0, c10 ? e.mr : 16'd0});
        chk("flags", {27'd0, o_flags}, {27'd0, e.fl});
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end
  task automatic issue(input logic [3:0] o, input logic [15:0] pa, input logic [15:0] qa, input bit push);
    exp_t e;
    @(negedge clk);
    op = o; p = pa; q = qa; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); p = 16'($urandom); q = 16'($urandom);
    if (push) begin
      e = model(o, pa, qa);
      e.acc = cyc;
      sbq.push_back(e);
      last = e;
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (!o_busy && sbq.size() == 0) return;
    end
    chk("idle_timeout", 32'd1, 32'd0);
    sbq.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_br", {16'd0, o_br}, 32'd0);
    chk("rst_mr", {16'd0, o_mr}, 32'd0);
    chk("rst_flags", {27'd0, o_flags}, 32'd0);
    chk("rst_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    issue(4'd0, 16'h7FFF, 16'h0001, 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1 chk("hold_br", {16'd0, o_br}, {16'd0, last.br});
    issue(4'd2, 16'hFFFE, 16'h0003, 1'b1);
    chk("busy_in_calc", {31'd0, o_busy}, 32'd1);
    wait_idle();
    issue(4'd2, 16'h0100, 16'h0100, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 4'd0; p = 16'($urandom); q = 16'($urandom);
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    c10 = 1'b0;
    #1 chk("c10_gate_off", {16'd0, o_mr}, 32'd0);
    c10 = 1'b1;
    #1 chk("c10_gate_on", {16'd0, o_mr}, 32'h1);
    c9 = 1'b0;
    issue(4'd7, 16'h8001, 16'h1234, 1'b1);
    wait_idle();
    c9 = 1'b1;
    #1 chk("c9_gate_on", {16'd0, o_br}, 32'hC000);
    chk("shr_cf", {31'd0, o_flags[3]}, 32'd1);
`ifdef ALU_SEQ_DIV_EN
    issue(4'd9, 16'hFFF9, 16'h0002, 1'b1);
    wait_idle();
    issue(4'd9, 16'h0005, 16'h0000, 1'b1);
    wait_idle();
    issue(4'd9, 16'h8000, 16'hFFFF, 1'b1);
    wait_idle();
`endif
    issue(4'd2, 16'h1234, 16'h5678, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_done", {31'd0, o_done}, 32'd0);
    chk("midrst_br_mr", {o_br, o_mr}, 32'd0);
    chk("midrst_flags", {27'd0, o_flags}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    issue(4'd0, 16'h0003, 16'h0004, 1'b1);
    wait_idle();
    for (int i = 0; i < 70; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), 1'b1);
      wait_idle();
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand, BR and MR width; legal range 8..32.
REQ-002 i_clk  in  1: single clock; all state updates on its rising edge.
REQ-003 i_rst_n  in  1: asynchronous, active-low reset.
REQ-004 i_acc_alu_p  in  WIDTH: operand P, signed two's complement.
REQ-005 i_acc_alu_q  in  WIDTH: operand Q, signed two's complement.
REQ-006 ctrl_alu_op  in  4: opcode; 0 ADD, 1 SUB, 2 MPY, 3 AND, 4 OR, 5 NOT, 6 SHL, 7 SHR (arithmetic), 8 XOR, 9 DIV; 10..15 reserved.
REQ-007 i_start  in  1: operation request, honoured only while o_busy=0.
REQ-008 C9  in  1: BR bus output enable.
REQ-009 C10  in  1: MR bus output enable.
REQ-010 o_br  out  WIDTH: BR when C9=1, else 0.
REQ-011 o_mr  out  WIDTH: MR when C10=1, else 0.
REQ-012 o_flags  out  5: {ZF, CF, OF, NF, MF}.
REQ-013 o_busy  out  1: high in every state except IDLE.
REQ-014 o_done  out  1: one-cycle pulse; BR, MR and flags are final while it is high.

Function
REQ-015 FSM states are IDLE, CALC and DONE; reset enters IDLE.
REQ-016 i_start in IDLE latches P, Q and the opcode on the same edge; later input changes have no effect on the operation.
REQ-017 Single-cycle ops (ADD, SUB, AND, OR, NOT, SHL, SHR, XOR, reserved) write BR, MR and flags on the accepting edge, then IDLE->DONE.
REQ-018 For single-cycle ops: result is in BR (WIDTH bits, wrap-around), MR=0; reserved opcodes give BR=0.
REQ-019 MPY: IDLE->CALC, one iteration per cycle for WIDTH cycles, then BR/MR/flags are written and CALC->DONE.
REQ-020 MPY result: {MR,BR} = full 2*WIDTH-bit signed product.
REQ-021 DONE lasts one cycle, asserts o_done, then returns to IDLE; i_start is ignored in CALC and DONE.
REQ-022 Latency: o_done is high 1 cycle after acceptance for single-cycle ops and WIDTH cycles after acceptance for MPY/DIV.
REQ-023 ZF: MPY tests {MR,BR}==0; DIV tests BR==0; all other ops test BR==0.
REQ-024 CF: SHL sets it to P[WIDTH-1], SHR to P[0]; all other ops clear it.
REQ-025 OF: signed overflow for ADD/SUB; MR not equal to the sign extension of BR for MPY; DIV per REQ-031/032; all other ops clear it.
REQ-026 NF=BR[WIDTH-1] for all ops.
REQ-027 MF=1 for MPY and DIV, 0 for all other ops.
REQ-028 BR, MR and flags hold their values between operations.

Reset
REQ-029 Asserting i_rst_n low at any time, including mid-CALC, immediately forces: state IDLE, iteration counter 0, BR=0, MR=0, flags=0, o_busy=0, o_done=0; the interrupted operation is abandoned with no result written.

Configuration
REQ-030 Macro ALU_SEQ_DIV_EN: when defined, DIV is an iterative op with the same CALC timing as MPY; when undefined, opcode 9 behaves as reserved and no divider logic is synthesised.
REQ-031 DIV result: BR = quotient truncated toward zero; MR = remainder with the dividend's sign; Q=0 completes in 1 cycle with BR=0, MR=P, OF=1.
REQ-032 DIV overflow: P=most-negative, Q=-1 gives BR=P, MR=0, OF=1.

Structure
REQ-033 Package alu_seq_pkg holds the opcode constants, the FSM state encoding and the flag bit indices.
REQ-034 Sub-module alu_seq_iter holds the iterative multiply/divide datapath and iteration counter, with start/done ports toward the FSM.

Verification (WIDTH=16)
REQ-035 ADD 0x7FFF+0x0001 -> o_done 1 cycle later; BR=0x8000, OF=1, NF=1, ZF=0.
REQ-036 MPY 0xFFFE*0x0003 (-2*3) -> o_done 16 cycles later; {MR,BR}=0xFFFFFFFA, OF=0, MF=1.
REQ-037 MPY 0x0100*0x0100 with i_start and new operands pulsed during CALC -> start ignored; MR=0x0001, BR=0x0000, OF=1.
REQ-038 DIV -7/2 (macro defined) -> BR=0xFFFD, MR=0xFFFF; DIV 5/0 -> BR=0, MR=5, OF=1 one cycle later.
REQ-039 SHR 0x8001 with C9=0 -> o_br=0; after C9=1 -> o_br=0xC000, CF=1.
REQ-040 Reset pulse during cycle 8 of MPY -> o_busy=0, BR=MR=0, flags=0, no o_done; next ADD completes normally.
